nn_seq_ctrl: RTL and testbench

Parametrised sequencer for the neural-network coprocessor. It generalises the fixed-state layer controller to configurable input, neuron and layer counts, and adds ready-based stalling, abort and ping-pong activation banking. It walks every layer, neuron and input in order, driving MAC, activation and write-back strobes plus weight, input and output addresses. It sits between the processor's start/done handshake and the datapath (weight ROM, activation RAM banks, MAC unit).

---
 rtl/nn_seq_pkg.sv | 20 ++
 rtl/nn_seq_ctrl_seq_counter.sv | 28 ++
 rtl/nn_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_nn_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_seq_pkg.sv
// Shared types and helpers for the neural-network layer sequencer.
package nn_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'b000,
    CLR  = 3'b001,
    MAC  = 3'b010,
    ACT  = 3'b011,
    WB   = 3'b100,
    DONE = 3'b101
  } nn_seq_state;

  // Index width for a count of v items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 32'd1) ? 32'd1 : 32'($clog2(v));
  endfunction

endpackage

// File: rtl/nn_seq_ctrl_seq_counter.sv
// Wrapping index counter 0..MAX-1 with clear priority over enable.
module seq_counter
  import nn_seq_pkg::*;
#(
  parameter int unsigned MAX = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       en,
  output logic [clog2_min1(MAX)-1:0] count,
  output logic                       last
);

  localparam int unsigned W = clog2_min1(MAX);

  assign last = (count == W'(MAX - 32'd1));

  // Count register: clear wins, otherwise step and wrap after the last value.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/nn_seq_ctrl.sv
// Layer/neuron/input sequencer driving MAC, activation and write-back strobes.
module nn_seq_ctrl
  import nn_seq_pkg::*;
#(
  parameter int unsigned N_IN    = 8,
  parameter int unsigned N_NEUR  = 4,
  parameter int unsigned N_LAYER = 2,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           ready,
  output logic                           busy,
  output logic                           done,
  output logic                           mac_clr,
  output logic                           mac_en,
  output logic                           act_en,
  output logic                           y_we,
  output logic [ADDR_W-1:0]              w_addr,
  output logic [clog2_min1(N_IN)-1:0]    x_addr,
  output logic [clog2_min1(N_NEUR)-1:0]  y_addr,
  output logic                           x_bank,
  output logic [clog2_min1(N_LAYER)-1:0] layer_idx
);

  localparam longint unsigned TOTAL_W = 64'(N_LAYER) * 64'(N_NEUR) * 64'(N_IN);
  localparam longint unsigned W_SPACE = 64'd1 << ADDR_W;

  if (N_IN < 1 || N_NEUR < 1 || N_LAYER < 1 || TOTAL_W > W_SPACE) begin : g_param_check
    $error("nn_seq_ctrl: counts must be >= 1 and all weights must fit in ADDR_W");
  end

  nn_seq_state state, state_nx;
  logic        i_last, n_last, l_last;
  logic        mac_acc, cnt_clr;
  logic        busy_nx, done_nx, mac_clr_nx, mac_en_nx, act_en_nx, y_we_nx;

  assign mac_acc = (state == MAC) && ready;
  assign cnt_clr = (state_nx == IDLE);
  assign x_bank  = layer_idx[0];

  seq_counter #(.MAX(N_IN)) u_i (
    .clk(clk), .reset(reset), .clr(cnt_clr), .en(mac_acc),
    .count(x_addr), .last(i_last)
  );

  seq_counter #(.MAX(N_NEUR)) u_n (
    .clk(clk), .reset(reset), .clr(cnt_clr), .en(state == WB),
    .count(y_addr), .last(n_last)
  );

  seq_counter #(.MAX(N_LAYER)) u_l (
    .clk(clk), .reset(reset), .clr(cnt_clr), .en((state == WB) && n_last),
    .count(layer_idx), .last(l_last)
  );

  // State register plus registered strobes, loaded from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      act_en  <= 1'b0;
      y_we    <= 1'b0;
    end else begin
      state   <= state_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      mac_clr <= mac_clr_nx;
      mac_en  <= mac_en_nx;
      act_en  <= act_en_nx;
      y_we    <= y_we_nx;
    end
  end

  // Next-state: walk inputs, neurons, layers; abort overrides everything.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CLR;
      CLR:     state_nx = MAC;
      MAC:     if (ready && i_last) state_nx = ACT;
      ACT:     state_nx = WB;
      WB:      state_nx = (n_last && l_last) ? DONE : CLR;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  // Output decode of the state about to be entered, one strobe per state.
  always_comb begin
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    mac_clr_nx = 1'b0;
    mac_en_nx  = 1'b0;
    act_en_nx  = 1'b0;
    y_we_nx    = 1'b0;
    busy_nx    = (state_nx != IDLE);
    done_nx    = (state_nx == DONE);
    mac_clr_nx = (state_nx == CLR);
    mac_en_nx  = (state_nx == MAC);
    act_en_nx  = (state_nx == ACT);
    y_we_nx    = (state_nx == WB);
  end

  // Weight address: one step per accepted MAC across the whole run.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      w_addr <= '0;
    end else if (mac_acc) begin
      w_addr <= w_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// Self-checking bench for nn_seq_ctrl: default, minimal and odd-sized configurations.
module tb_nn_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic reset, start, abort, ready;
  logic one, zero;

  // Default configuration
  logic       busy, done, mac_clr, mac_en, act_en, y_we, x_bank;
  logic [7:0] w_addr;
  logic [2:0] x_addr;
  logic [1:0] y_addr;
  logic [0:0] layer_idx;
  logic [20:0] mvec;
  assign mvec = {busy, done, mac_clr, mac_en, act_en, y_we, w_addr, x_addr, y_addr, x_bank, layer_idx};

  nn_seq_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ready(ready),
    .busy(busy), .done(done), .mac_clr(mac_clr), .mac_en(mac_en), .act_en(act_en),
    .y_we(y_we), .w_addr(w_addr), .x_addr(x_addr), .y_addr(y_addr),
    .x_bank(x_bank), .layer_idx(layer_idx)
  );

  // 1/1/1 configuration
  logic       s1_start, s1_busy, s1_done, s1_mac_clr, s1_mac_en, s1_act_en, s1_y_we, s1_x_bank;
  logic [7:0] s1_w_addr;
  logic [0:0] s1_x_addr, s1_y_addr, s1_layer_idx;

  nn_seq_ctrl #(.N_IN(1), .N_NEUR(1), .N_LAYER(1), .ADDR_W(8)) u_s1 (
    .clk(clk), .reset(reset), .start(s1_start), .abort(zero), .ready(one),
    .busy(s1_busy), .done(s1_done), .mac_clr(s1_mac_clr), .mac_en(s1_mac_en),
    .act_en(s1_act_en), .y_we(s1_y_we), .w_addr(s1_w_addr), .x_addr(s1_x_addr),
    .y_addr(s1_y_addr), .x_bank(s1_x_bank), .layer_idx(s1_layer_idx)
  );

  // 3/5/3 configuration
  logic       s3_start, s3_busy, s3_done, s3_mac_clr, s3_mac_en, s3_act_en, s3_y_we, s3_x_bank;
  logic [7:0] s3_w_addr;
  logic [1:0] s3_x_addr, s3_layer_idx;
  logic [2:0] s3_y_addr;

  nn_seq_ctrl #(.N_IN(3), .N_NEUR(5), .N_LAYER(3), .ADDR_W(8)) u_s3 (
    .clk(clk), .reset(reset), .start(s3_start), .abort(zero), .ready(one),
    .busy(s3_busy), .done(s3_done), .mac_clr(s3_mac_clr), .mac_en(s3_mac_en),
    .act_en(s3_act_en), .y_we(s3_y_we), .w_addr(s3_w_addr), .x_addr(s3_x_addr),
    .y_addr(s3_y_addr), .x_bank(s3_x_bank), .layer_idx(s3_layer_idx)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int stall_at;   // accepted-step index at which ready drops (-1: never)
    int stall_len;  // number of ready=0 cycles
    int abort_cyc;  // cycle in which abort is pulsed (-1: never)
    bit poke;       // pulse start while busy
    int exp_done;   // expected done cycle (-1: none)
    int exp_macs;   // expected accepted MAC steps
  } run_t;

  typedef struct {
    logic [4:0] strb;  // {mac_clr, mac_en, act_en, y_we, done}
    logic       bsy;
    logic [7:0] w;
  } vec_t;

  // One run on the default DUT; expected addresses are queued up front and consumed per step.
  task automatic main_run(input run_t r);
    int wq[$];
    int yq[$];
    int cyc, acc, stalled, done_cyc, ycnt, maxw;
    bit fin;
    for (int k = 0; k < 64; k++) wq.push_back(k);
    for (int n = 0; n < 8; n++) yq.push_back(n);
    cyc = 0; acc = 0; stalled = 0; done_cyc = -1; ycnt = 0; maxw = 0; fin = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; abort = 1'b0; ready = 1'b1;
    while (!fin && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
      start = r.poke && (cyc == 20 || cyc == 60);
      abort = (cyc == r.abort_cyc);
      ready = 1'b1;
      if (mac_en && acc == r.stall_at && stalled < r.stall_len) begin
        ready = 1'b0;
        stalled++;
      end
      #2;
      if (cyc == 1) chk("first_clr", mac_clr, 1);
      if (busy) chk("one_strobe", $countones({mac_clr, mac_en, act_en, y_we, done}), 1);
      if (mac_en) begin
        if (wq.size() == 0) chk("extra_mac", 1, 0);
        else begin
          chk("w_addr", w_addr, wq[0]);
          chk("x_addr", x_addr, wq[0] % 8);
          if (ready && !abort) begin
            void'(wq.pop_front());
            acc++;
          end
        end
      end
      if (int'(w_addr) > maxw) maxw = int'(w_addr);
      if (y_we) begin
        ycnt++;
        if (yq.size() == 0) chk("extra_wb", 1, 0);
        else begin
          chk("y_addr", y_addr, yq[0] % 4);
          chk("x_bank", x_bank, yq[0] / 4);
          void'(yq.pop_front());
        end
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (r.abort_cyc > 0 && cyc == r.abort_cyc + 1) begin
        chk("abort_idle", mvec, 0);
        fin = 1'b1;
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        chk("idle_after_done", busy, 0);
        chk("w_addr_cleared", w_addr, 0);
        fin = 1'b1;
      end
    end
    start = 1'b0; abort = 1'b0; ready = 1'b1;
    chk("run_finished", fin, 1);
    chk("done_cycle", done_cyc, r.exp_done);
    chk("mac_count", acc, r.exp_macs);
    if (r.abort_cyc < 0) begin
      chk("w_addr_max", maxw, 64);
      chk("wb_count", ycnt, 8);
    end
  endtask

  run_t runs[7];
  vec_t v1[7];

  initial begin
    int cyc, macs, wbs, maxw, maxl, done_cyc;
    bit got;

    runs[0] = '{-1, 0, -1, 1'b0, 89, 64};  // plain run
    runs[1] = '{ 4, 3, -1, 1'b0, 92, 64};  // 5th step of neuron 0 stalled 3 cycles
    runs[2] = '{-1, 0, -1, 1'b1, 89, 64};  // start pulses while busy
    runs[3] = '{20, 1, -1, 1'b0, 90, 64};  // single stall mid-layer
    runs[4] = '{-1, 0, 70, 1'b0, -1, 50};  // abort in layer 1, neuron 2, MAC
    runs[5] = '{-1, 0, -1, 1'b0, 89, 64};  // fresh run after abort
    runs[6] = '{ 0, 2, -1, 1'b0, 91, 64};  // stall on the very first step

    v1[0] = '{5'b10000, 1'b1, 8'd0};  // CLR
    v1[1] = '{5'b01000, 1'b1, 8'd0};  // MAC
    v1[2] = '{5'b00100, 1'b1, 8'd1};  // ACT
    v1[3] = '{5'b00010, 1'b1, 8'd1};  // WB
    v1[4] = '{5'b00001, 1'b1, 8'd1};  // DONE
    v1[5] = '{5'b00000, 1'b0, 8'd0};  // IDLE, start sampled again
    v1[6] = '{5'b10000, 1'b1, 8'd0};  // back-to-back CLR

    one = 1'b1; zero = 1'b0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
    s1_start = 1'b0; s3_start = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    chk("reset_main", mvec, 0);
    chk("reset_s1", {s1_busy, s1_done, s1_mac_clr, s1_mac_en, s1_act_en, s1_y_we, s1_w_addr}, 0);
    chk("reset_s3", {s3_busy, s3_done, s3_w_addr, s3_x_addr, s3_y_addr, s3_layer_idx, s3_x_bank}, 0);
    @(posedge clk); #2;
    reset = 1'b0;

    for (int t = 0; t < 7; t++) main_run(runs[t]);

    // Reset during ACT clears everything on the next cycle.
    @(posedge clk); #2;
    start = 1'b1; cyc = 0; got = 1'b0;
    while (!got && cyc < 30) begin
      @(posedge clk); #2;
      cyc++;
      start = 1'b0;
      #2;
      if (act_en) got = 1'b1;
    end
    chk("act_cycle", cyc, 10);
    reset = 1'b1;
    @(posedge clk); #4;
    chk("reset_mid_act", mvec, 0);
    reset = 1'b0;

    // start together with abort in IDLE: abort wins.
    @(posedge clk); #2;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0;
    #2;
    chk("start_abort_idle", busy, 0);
    @(posedge clk); #4;
    chk("start_abort_idle2", busy, 0);

    // Minimal configuration, start held high: one state per cycle, then back-to-back.
    @(posedge clk); #2;
    s1_start = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #4;
      chk("s1_strobes", {s1_mac_clr, s1_mac_en, s1_act_en, s1_y_we, s1_done}, v1[c].strb);
      chk("s1_busy", s1_busy, v1[c].bsy);
      chk("s1_w_addr", s1_w_addr, v1[c].w);
    end
    #0 s1_start = 1'b0;
    repeat (8) @(posedge clk);
    #4;
    chk("s1_idle", s1_busy, 0);

    // Odd-sized configuration.
    @(posedge clk); #2;
    s3_start = 1'b1; cyc = 0; macs = 0; wbs = 0; maxw = 0; maxl = 0; done_cyc = -1;
    while (cyc < 200 && !(done_cyc > 0 && cyc > done_cyc)) begin
      @(posedge clk); #2;
      cyc++;
      s3_start = 1'b0;
      #2;
      if (s3_mac_en) macs++;
      if (s3_y_we) wbs++;
      if (int'(s3_w_addr) > maxw) maxw = int'(s3_w_addr);
      if (int'(s3_layer_idx) > maxl) maxl = int'(s3_layer_idx);
      if (s3_done && done_cyc < 0) done_cyc = cyc;
    end
    chk("s3_done_cycle", done_cyc, 91);
    chk("s3_macs", macs, 45);
    chk("s3_w_addr_max", maxw, 45);
    chk("s3_wb_count", wbs, 15);
    chk("s3_layer_max", maxl, 2);
    chk("s3_idle", s3_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
